// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit positions and FSM encoding shared by the UART transmitter
package uart_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    function automatic logic [15:0] bit_period_m1(input logic [15:0] div);
        return div == 16'd0 ? 16'd0 : div - 16'd1;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: bridge-side register bus plus the interrupt and serial line of the transmitter
interface uart_tx_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        TXD;
    modport master (output Addr, WE, Din, input Dout, IRQ, TXD);
    modport slave (input Addr, WE, Din, output Dout, IRQ, TXD);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period countdown, one-cycle tick at the end of each period
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        active,
    input  logic [15:0] div,
    output logic        tick
);
    logic [15:0] per;
    logic [15:0] cnt;
    assign tick = active && cnt == 16'd0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            per <= 16'd0;
            cnt <= 16'd0;
        end else if (load) begin
            per <= bit_period_m1(div);
            cnt <= bit_period_m1(div);
        end else if (active) begin
            cnt <= cnt == 16'd0 ? per : cnt - 16'd1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 transmitter with programmable divisor, status flags and interrupt
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input logic        clk,
    input logic        reset,
    uart_tx_if.slave   bus
);
    logic        en;
    logic        im;
    logic        done;
    logic        ovr;
    logic [15:0] div;
    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  sh;
    logic        tick;
    logic [1:0]  a;
    logic        busy;
    logic        wr_data;
    logic        wr_stat;
    logic        load;
    logic [31:0] ctrl_v;
    logic [31:0] stat_v;
    logic        unused_bits;
    assign a           = bus.Addr[3:2];
    assign busy        = state != S_IDLE;
    assign wr_data     = bus.WE && a == REG_DATA;
    assign wr_stat     = bus.WE && a == REG_STATUS;
    assign load        = wr_data && en && !busy;
    assign unused_bits = ^{bus.Addr[31:4], bus.Din[31:16]};
    uart_baud_tick u_baud (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .active (busy),
        .div    (div),
        .tick   (tick)
    );
    always_comb begin
        ctrl_v = '0;
        ctrl_v[CTRL_EN] = en;
        ctrl_v[CTRL_IM] = im;
        stat_v = '0;
        stat_v[ST_BUSY] = busy;
        stat_v[ST_DONE] = done;
        stat_v[ST_OVR]  = ovr;
        bus.Dout = a == REG_CTRL   ? ctrl_v :
                   a == REG_DIV    ? {16'd0, div} :
                   a == REG_STATUS ? stat_v : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            en      <= 1'b0;
            im      <= 1'b0;
            div     <= DIV_RESET;
            done    <= 1'b0;
            ovr     <= 1'b0;
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            sh      <= 8'd0;
            bus.TXD <= 1'b1;
            bus.IRQ <= 1'b0;
        end else begin
            if (bus.WE && a == REG_CTRL) begin
                en <= bus.Din[CTRL_EN];
                im <= bus.Din[CTRL_IM];
            end
            if (bus.WE && a == REG_DIV) div <= bus.Din[15:0];
            if (wr_stat) begin
                done <= 1'b0;
                ovr  <= 1'b0;
            end
            if (wr_data && en && busy) ovr <= 1'b1;
            // clearing STATUS drops IRQ on the same edge as DONE
            bus.IRQ <= done && im && !wr_stat;
            case (state)
                S_IDLE: if (load) begin
                    sh      <= bus.Din[7:0];
                    bit_cnt <= 3'd0;
                    state   <= S_START;
                    bus.TXD <= 1'b0;
                end
                S_START: if (tick) begin
                    state   <= S_DATA;
                    bus.TXD <= sh[0];
                    sh      <= {1'b0, sh[7:1]};
                end
                S_DATA: if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state   <= S_STOP;
                        bus.TXD <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        bus.TXD <= sh[0];
                        sh      <= {1'b0, sh[7:1]};
                    end
                end
                S_STOP: if (tick) begin
                    state   <= S_IDLE;
                    bit_cnt <= 3'd0;
                    done    <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed frame checks against an arithmetic serial-line model
module tb_uart_tx;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    uart_tx_if bus();
    uart_tx dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = {28'd0, a};
        bus.Din  = d;
        bus.WE   = 1'b1;
        @(negedge clk);
        bus.WE   = 1'b0;
    endtask
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.Addr = {28'd0, a};
        #1;
        d = bus.Dout;
    endtask
    // Expected line level i cycles into a frame: start bit, 8 data bits LSB first, stop bit
    function automatic logic line_at(input logic [7:0] b, input int d, input int i);
        int k;
        k = i / d;
        return k == 0 ? 1'b0 : k < 9 ? b[k-1] : 1'b1;
    endfunction
    task automatic watch(input logic [7:0] b, input int d, input int inj, input logic [1:0] ia,
                         input logic [31:0] idat, output int len, output int errs,
                         output logic [31:0] st_mid, output logic [31:0] st_end);
        errs = 0; len = 0; st_mid = 0; st_end = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == inj) begin
                bus.Addr = {28'd0, ia};
                bus.Din  = idat;
                bus.WE   = 1'b1;
                #1;
            end else begin
                bus.WE   = 1'b0;
                bus.Addr = {28'd0, REG_STATUS};
                #1;
                if (i == inj + 1) st_mid = bus.Dout;
                if (!bus.Dout[ST_BUSY]) begin
                    st_end = bus.Dout;
                    len = i;
                    break;
                end
            end
            if (bus.TXD !== line_at(b, d, i)) errs++;
            @(negedge clk);
        end
        bus.WE = 1'b0;
    endtask
    initial begin
        logic [31:0] v, sm, se;
        logic [7:0]  b;
        int          len, errs, d;
        reset = 1'b0; bus.WE = 1'b0; bus.Addr = '0; bus.Din = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, bus.TXD}, 1);
        check("rst_irq", {31'd0, bus.IRQ}, 0);
        wr(REG_CTRL, 32'h9);
        rd(REG_CTRL, v);   check("rst_ctrl_we_ignored", v, 0);
        rd(REG_DIV, v);    check("rst_div", v, 434);
        rd(REG_STATUS, v); check("rst_status", v, 0);
        rd(REG_DATA, v);   check("rst_data", v, 0);
        reset = 1'b1;
        @(negedge clk);
        wr(REG_CTRL, 32'h1); wr(REG_DIV, 32'd4);
        rd(REG_CTRL, v); check("ctrl_rd", v, 1);
        wr(REG_DATA, 32'h55);
        watch(8'h55, 4, -1, 2'd0, 0, len, errs, sm, se);
        check("basic_len", len, 40); check("basic_bits", errs, 0);
        check("basic_status", se, 32'h2); check("basic_irq", {31'd0, bus.IRQ}, 0);
        wr(REG_STATUS, 0); wr(REG_CTRL, 32'h9); wr(REG_DIV, 32'd2);
        rd(REG_CTRL, v); check("ctrl_im_rd", v, 9);
        wr(REG_DATA, 32'hA3);
        watch(8'hA3, 2, -1, 2'd0, 0, len, errs, sm, se);
        check("irq_len", len, 20); check("irq_bits", errs, 0); check("irq_done", se, 32'h2);
        check("irq_lags_done", {31'd0, bus.IRQ}, 0);
        @(negedge clk);
        check("irq_rise", {31'd0, bus.IRQ}, 1);
        wr(REG_STATUS, 0);
        rd(REG_STATUS, v); check("irq_clr_status", v, 0);
        check("irq_clr", {31'd0, bus.IRQ}, 0);
        wr(REG_CTRL, 32'h1); wr(REG_DIV, 32'd4); wr(REG_DATA, 32'h0F);
        watch(8'h0F, 4, 5, REG_DATA, 32'hF0, len, errs, sm, se);
        check("ovr_mid_status", sm, 32'h5); check("ovr_bits", errs, 0);
        check("ovr_len", len, 40); check("ovr_end_status", se, 32'h6);
        wr(REG_STATUS, 0); wr(REG_DIV, 32'd0); wr(REG_DATA, 32'hFF);
        watch(8'hFF, 1, -1, 2'd0, 0, len, errs, sm, se);
        check("div0_len", len, 10); check("div0_bits", errs, 0);
        wr(REG_DIV, 32'd4); wr(REG_DATA, 32'hC6);
        watch(8'hC6, 4, 10, REG_DIV, 32'd8, len, errs, sm, se);
        check("divchg_cur_len", len, 40); check("divchg_cur_bits", errs, 0);
        wr(REG_DATA, 32'h39);
        watch(8'h39, 8, -1, 2'd0, 0, len, errs, sm, se);
        check("divchg_next_len", len, 80); check("divchg_next_bits", errs, 0);
        wr(REG_STATUS, 0); wr(REG_CTRL, 32'h0); wr(REG_DATA, 32'h12);
        @(negedge clk);
        rd(REG_STATUS, v); check("en0_status", v, 0);
        check("en0_txd", {31'd0, bus.TXD}, 1);
        wr(REG_CTRL, 32'h1);
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 5);
            b = 8'($urandom);
            wr(REG_DIV, d);
            wr(REG_DATA, {24'd0, b});
            d = d == 0 ? 1 : d;
            watch(b, d, -1, 2'd0, 0, len, errs, sm, se);
            check($sformatf("rand%0d_len", r), len, 10 * d);
            check($sformatf("rand%0d_bits", r), errs, 0);
        end
        wr(REG_STATUS, 0); wr(REG_DIV, 32'd4); wr(REG_DATA, 32'h00);
        repeat (15) @(negedge clk);
        check("midrst_txd_low", {31'd0, bus.TXD}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_txd", {31'd0, bus.TXD}, 1);
        rd(REG_STATUS, v); check("midrst_status", v, 0);
        rd(REG_DIV, v);    check("midrst_div", v, 434);
        rd(REG_CTRL, v);   check("midrst_ctrl", v, 0);
        reset = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
